// File: rtl/trap_peak_finder_if.sv
// ---------------------------------------------------------------------------
// trap_peak_finder_if
//
// Purpose: bundles the sample input and the event output of the trapezoid
// peak finder so the block and its environment share one port declaration.
//
// Signals:
//   data_in    signed filter sample, one per clock (environment -> finder)
//   out_ready  consumer accepts the event held in the output register
//   out_valid  event present in the output register
//   out_amp    signed peak value of the event
//   out_ts     timestamp of the first sample equal to the peak
//   out_width  samples above threshold, saturating
//   out_pileup width reached the pile-up limit
//   drop_cnt   events lost to backpressure, saturating
//   busy       finder is not idle
//
// Modports:
//   master  environment side (drives data_in and out_ready)
//   slave   peak finder side (drives the event fields and status)
// ---------------------------------------------------------------------------
interface trap_peak_finder_if #(
  parameter int DATA_W  = 21,
  parameter int TS_W    = 32,
  parameter int WIDTH_W = 8
);

  logic signed [DATA_W-1:0]  data_in;
  logic                      out_ready;
  logic                      out_valid;
  logic signed [DATA_W-1:0]  out_amp;
  logic        [TS_W-1:0]    out_ts;
  logic        [WIDTH_W-1:0] out_width;
  logic                      out_pileup;
  logic        [15:0]        drop_cnt;
  logic                      busy;

  modport master (
    output data_in,
    output out_ready,
    input  out_valid,
    input  out_amp,
    input  out_ts,
    input  out_width,
    input  out_pileup,
    input  drop_cnt,
    input  busy
  );

  modport slave (
    input  data_in,
    input  out_ready,
    output out_valid,
    output out_amp,
    output out_ts,
    output out_width,
    output out_pileup,
    output drop_cnt,
    output busy
  );

endinterface

// File: rtl/trap_peak_finder.sv
// ---------------------------------------------------------------------------
// trap_peak_finder
//
// Purpose: sits behind the trapezoidal shaping filter. Each shaped pulse is
// detected by a strict threshold crossing, its maximum and the timestamp of
// the first sample reaching that maximum are tracked, and on the first
// sample back at or below threshold one event {amp, ts, width, pileup} is
// offered to a valid/ready output register. After an event the input is
// ignored for HOLDOFF cycles, then the finder waits for the signal to drop
// below threshold before it can re-arm.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous, active-low reset
//   bus     trap_peak_finder_if.slave: data_in/out_ready in, event fields,
//           drop_cnt and busy out
//
// Parameters:
//   DATA_W     signed sample width
//   THRESHOLD  signed trigger level, sample is above iff data_in > THRESHOLD
//   MAX_WIDTH  width at or beyond which the event is flagged pile-up
//   HOLDOFF    dead-time cycles after the end of an event
//   TS_W       timestamp counter width
//   WIDTH_W    width field size
// ---------------------------------------------------------------------------
module trap_peak_finder #(
  parameter int        DATA_W    = 21,
  parameter int signed THRESHOLD = 100,
  parameter int        MAX_WIDTH = 200,
  parameter int        HOLDOFF   = 4,
  parameter int        TS_W      = 32,
  parameter int        WIDTH_W   = 8
) (
  input logic               clk,
  input logic               reset,
  trap_peak_finder_if.slave bus
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam logic signed [DATA_W-1:0] THR_S = DATA_W'(THRESHOLD);

  // Pile-up compare is done at 32 bits so a MAX_WIDTH beyond the width
  // field range simply never flags.
  localparam int unsigned MAXW_U = MAX_WIDTH;

  // Holdoff counter runs 0 .. HOLDOFF-1 while in HOLD.
  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RISE     = 2'd1,
    ST_HOLD     = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                    state_q,    state_d;
  logic        [TS_W-1:0]    ts_q;
  logic signed [DATA_W-1:0]  max_q,      max_d;
  logic        [TS_W-1:0]    max_ts_q,   max_ts_d;
  logic        [WIDTH_W-1:0] width_q,    width_d;
  logic        [HC_W-1:0]    hold_cnt_q, hold_cnt_d;

  logic                      valid_q,    valid_d;
  logic signed [DATA_W-1:0]  amp_q,      amp_d;
  logic        [TS_W-1:0]    ev_ts_q,    ev_ts_d;
  logic        [WIDTH_W-1:0] ev_width_q, ev_width_d;
  logic                      pileup_q,   pileup_d;
  logic        [15:0]        drop_q,     drop_d;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic signed [DATA_W-1:0]  sample;
  logic                      above;
  logic                      new_max;
  logic        [WIDTH_W-1:0] width_inc;
  logic                      ev_end;
  logic                      ev_load;
  logic                      ev_pileup;

  assign sample  = bus.data_in;
  assign above   = (sample > THR_S);    // both operands signed
  assign new_max = (sample > max_q);    // strict: ties keep the earlier ts

  assign width_inc = (width_q == {WIDTH_W{1'b1}}) ? width_q
                                                   : width_q + WIDTH_W'(1);

  // width_q at the ending edge already excludes the terminating sample.
  assign ev_pileup = (32'(width_q) >= MAXW_U);

  // The output register can take a new event when it is empty or is being
  // emptied on this very edge; otherwise the event is lost.
  assign ev_load = ev_end && (!valid_q || bus.out_ready);

  // -------------------------------------------------------------------------
  // Pulse tracking FSM: next state and tracking registers
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    max_d      = max_q;
    max_ts_d   = max_ts_q;
    width_d    = width_q;
    hold_cnt_d = hold_cnt_q;
    ev_end     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (above) begin
          state_d  = ST_RISE;
          max_d    = sample;
          max_ts_d = ts_q;
          width_d  = WIDTH_W'(1);
        end
      end

      ST_RISE: begin
        if (above) begin
          width_d = width_inc;
          if (new_max) begin
            max_d    = sample;
            max_ts_d = ts_q;
          end
        end else begin
          ev_end     = 1'b1;
          hold_cnt_d = '0;
          state_d    = (HOLDOFF > 0) ? ST_HOLD : ST_WAIT_LOW;
        end
      end

      ST_HOLD: begin
        // Input is ignored here; only the dead-time counter advances.
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = ST_WAIT_LOW;
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end

      ST_WAIT_LOW: begin
        // A signal still above threshold must fall before re-arming.
        if (!above) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output register and drop counter: next state
  // -------------------------------------------------------------------------
  always_comb begin
    valid_d    = valid_q;
    amp_d      = amp_q;
    ev_ts_d    = ev_ts_q;
    ev_width_d = ev_width_q;
    pileup_d   = pileup_q;
    drop_d     = drop_q;

    if (ev_load) begin
      valid_d    = 1'b1;
      amp_d      = max_q;
      ev_ts_d    = max_ts_q;
      ev_width_d = width_q;
      pileup_d   = ev_pileup;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end

    if (ev_end && !ev_load && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ts_q       <= '0;
      max_q      <= '0;
      max_ts_q   <= '0;
      width_q    <= '0;
      hold_cnt_q <= '0;
      valid_q    <= 1'b0;
      amp_q      <= '0;
      ev_ts_q    <= '0;
      ev_width_q <= '0;
      pileup_q   <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_q + TS_W'(1);   // wraps naturally
      max_q      <= max_d;
      max_ts_q   <= max_ts_d;
      width_q    <= width_d;
      hold_cnt_q <= hold_cnt_d;
      valid_q    <= valid_d;
      amp_q      <= amp_d;
      ev_ts_q    <= ev_ts_d;
      ev_width_q <= ev_width_d;
      pileup_q   <= pileup_d;
      drop_q     <= drop_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.out_valid  = valid_q;
  assign bus.out_amp    = amp_q;
  assign bus.out_ts     = ev_ts_q;
  assign bus.out_width  = ev_width_q;
  assign bus.out_pileup = pileup_q;
  assign bus.drop_cnt   = drop_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_peak_finder.sv
// ---------------------------------------------------------------------------
// tb_trap_peak_finder
//
// Directed bench for trap_peak_finder with THRESHOLD=100, MAX_WIDTH=8,
// HOLDOFF=4. Inputs are driven 1 time unit after the rising edge and
// outputs are sampled 1 time unit after the following rising edge. The
// variable cyc mirrors the timestamp of the sample being driven.
// ---------------------------------------------------------------------------
module tb_trap_peak_finder;

  localparam int DW   = 21;
  localparam int TSW  = 32;
  localparam int WW   = 8;
  localparam int MAXW = 8;
  localparam int HO   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  trap_peak_finder_if #(.DATA_W(DW), .TS_W(TSW), .WIDTH_W(WW)) bus ();

  trap_peak_finder #(
    .DATA_W   (DW),
    .THRESHOLD(100),
    .MAX_WIDTH(MAXW),
    .HOLDOFF  (HO),
    .TS_W     (TSW),
    .WIDTH_W  (WW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit rst;     // apply a reset before this vector
    int d;
    bit rdy;
    bit v;
    int amp;
    int ts;
    int w;
    bit pu;
    bit busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, int d, bit rdy, bit v, int amp,
                              int ts, int w, bit pu, bit busy_e);
    vec_t e;
    e.rst = rst; e.d = d; e.rdy = rdy; e.v = v; e.amp = amp;
    e.ts = ts; e.w = w; e.pu = pu; e.busy = busy_e;
    tbl.push_back(e);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit v, input int amp,
                           input int ts, input int w, input bit pu,
                           input int drop, input bit busy_e);
    check({tag, "_valid"},  longint'(bus.out_valid), longint'(v));
    check({tag, "_amp"},    longint'($signed(bus.out_amp)), longint'(amp));
    check({tag, "_ts"},     longint'(bus.out_ts), longint'(ts));
    check({tag, "_width"},  longint'(bus.out_width), longint'(w));
    check({tag, "_pileup"}, longint'(bus.out_pileup), longint'(pu));
    check({tag, "_drop"},   longint'(bus.drop_cnt), longint'(drop));
    check({tag, "_busy"},   longint'(bus.busy), longint'(busy_e));
    $display("txn %s: valid=%0d amp=%0d ts=%0d width=%0d pileup=%0d drop=%0d busy=%0d",
             tag, bus.out_valid, $signed(bus.out_amp), bus.out_ts,
             bus.out_width, bus.out_pileup, bus.drop_cnt, bus.busy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply(input int d, input bit r);
    bus.data_in   = DW'(d);
    bus.out_ready = r;
    tick();
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    bus.data_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int e;

    bus.data_in   = '0;
    bus.out_ready = 1'b0;

    // ---------------- table: idle, simple pulse, plateau ----------------
    // Idle after reset: 20 samples of 0.
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 20; i++) add(0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Simple pulse 0,50,150,300,250,120,80,0 on ts 10..17.
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 11; i++) add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0,  50, 1, 0,   0,  0, 0, 0, 0);   // ts11: not above
    add(0, 150, 1, 0,   0,  0, 0, 0, 1);   // ts12: trigger
    add(0, 300, 1, 0,   0,  0, 0, 0, 1);
    add(0, 250, 1, 0,   0,  0, 0, 0, 1);
    add(0, 120, 1, 0,   0,  0, 0, 0, 1);
    add(0,  80, 1, 1, 300, 13, 4, 0, 1);   // ts16: pulse ends, event out
    add(0,   0, 1, 0, 300, 13, 4, 0, 1);   // consumed, hold 1
    add(0,   0, 1, 0, 300, 13, 4, 0, 1);
    add(0,   0, 1, 0, 300, 13, 4, 0, 1);
    add(0,   0, 1, 0, 300, 13, 4, 0, 1);   // last hold cycle
    add(0,   0, 1, 0, 300, 13, 4, 0, 0);   // wait-low sees 0 -> idle

    // Plateau 0,200,400,400,90 on ts 5..9: earlier ts of equal peaks kept.
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 6; i++) add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 200, 1, 0,   0, 0, 0, 0, 1);
    add(0, 400, 1, 0,   0, 0, 0, 0, 1);
    add(0, 400, 1, 0,   0, 0, 0, 0, 1);
    add(0,  90, 1, 1, 400, 7, 3, 0, 1);
    add(0,   0, 1, 0, 400, 7, 3, 0, 1);
    add(0,   0, 1, 0, 400, 7, 3, 0, 1);
    add(0,   0, 1, 0, 400, 7, 3, 0, 1);
    add(0,   0, 1, 0, 400, 7, 3, 0, 1);
    add(0,   0, 1, 0, 400, 7, 3, 0, 0);

    // ---------------- reset state ----------------
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i].d, tbl[i].rdy);
      check_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].amp, tbl[i].ts,
                tbl[i].w, tbl[i].pu, 0, tbl[i].busy);
    end

    // ---------------- backpressure and drops ----------------
    do_reset();
    apply(0, 0);
    apply(150, 0); apply(300, 0); apply(150, 0);
    apply(0, 0);                                    // ends, peak at ts2
    check_out("bp_first", 1, 300, 2, 3, 0, 0, 1);
    repeat (20) apply(0, 0);
    check_out("bp_held", 1, 300, 2, 3, 0, 0, 0);
    apply(200, 0); apply(500, 0);
    apply(0, 0);                                    // second event lost
    check_out("bp_drop", 1, 300, 2, 3, 0, 1, 1);
    repeat (6) apply(0, 0);
    apply(0, 1);                                    // one-cycle accept
    check_out("bp_ack", 0, 300, 2, 3, 0, 1, 0);
    t = cyc;
    apply(250, 0);
    apply(0, 0);                                    // register empty: loads
    check_out("bp_reload", 1, 250, t, 1, 0, 1, 1);
    repeat (6) apply(0, 0);
    t = cyc;
    apply(600, 0);
    apply(0, 1);                                    // full but accepted: loads
    check_out("bp_swap", 1, 600, t, 1, 0, 1, 1);
    apply(0, 1);
    check_out("bp_swap_ack", 0, 600, t, 1, 0, 1, 1);

    // ---------------- pile-up and width boundaries ----------------
    do_reset();
    apply(0, 1);
    repeat (10) apply(500, 1);
    apply(0, 1);
    check_out("pu_w10", 1, 500, 1, 10, 1, 0, 1);
    repeat (6) apply(0, 1);
    t = cyc;
    repeat (8) apply(300, 1);
    apply(0, 1);
    check_out("pu_w8", 1, 300, t, 8, 1, 0, 1);
    repeat (6) apply(0, 1);
    t = cyc;
    repeat (7) apply(300, 1);
    apply(0, 1);                                    // ending edge E
    check_out("pu_w7", 1, 300, t, 7, 0, 0, 1);

    // Re-rise during holdoff, held past it: no retrigger until it drops.
    apply(0, 1);                                    // E+1
    check_out("wl_e1", 0, 300, t, 7, 0, 0, 1);
    for (int k = 2; k <= 8; k++) begin
      apply(200, 1);
      check_out($sformatf("wl_e%0d", k), 0, 300, t, 7, 0, 0, 1);
    end
    apply(0, 1);                                    // E+9: drops -> idle
    check_out("wl_drop", 0, 300, t, 7, 0, 0, 0);
    apply(100, 1);                                  // equal to threshold
    check_out("thr_eq", 0, 300, t, 7, 0, 0, 0);
    apply(-500, 1);                                 // undershoot
    check_out("undershoot", 0, 300, t, 7, 0, 0, 0);
    e = cyc;
    apply(101, 1);
    apply(0, 1);
    check_out("thr_p1", 1, 101, e, 1, 0, 0, 1);

    // ---------------- asynchronous reset mid-pulse ----------------
    do_reset();
    apply(0, 0);
    apply(400, 0);
    apply(0, 0);
    check_out("ar_ev", 1, 400, 1, 1, 0, 0, 1);
    repeat (6) apply(0, 0);
    apply(200, 0);
    apply(0, 0);
    check_out("ar_drop", 1, 400, 1, 1, 0, 1, 1);
    repeat (6) apply(0, 0);
    apply(150, 0);
    apply(300, 0);
    check_out("ar_rise", 1, 400, 1, 1, 0, 1, 1);
    #2;
    reset = 1'b0;                                   // between clock edges
    #1;
    check_out("ar_async", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
    repeat (5) apply(0, 1);
    check_out("ar_quiet", 0, 0, 0, 0, 0, 0, 0);
    apply(200, 1);                                  // ts5
    apply(0, 1);
    check_out("ar_new", 1, 200, 5, 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
